// File: rtl/mem_stage_pkg.sv
// Shared widths, opcodes, FSM states and the Writeback-bound record
// used by the MEM pipeline stage.
package mem_stage_pkg;

  localparam int unsigned OPCODE_WIDTH = 8;
  localparam int unsigned REG_WIDTH    = 16;
  localparam int unsigned IDX_WIDTH    = 4;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 8'h01;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDW = 8'h10;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDB = 8'h11;
  localparam logic [OPCODE_WIDTH-1:0] OP_STW = 8'h12;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [REG_WIDTH-1:0]    alu_out;
    logic [REG_WIDTH-1:0]    mem_out;
    logic [IDX_WIDTH-1:0]    dest_reg_idx;
    logic                    fetch_stall;
    logic                    dep_stall;
  } wb_t;

  localparam wb_t WB_BUBBLE = '{opcode: '0, alu_out: '0, mem_out: '0,
                                dest_reg_idx: '0, fetch_stall: 1'b1,
                                dep_stall: 1'b0};

  function automatic logic is_mem_op(input logic [OPCODE_WIDTH-1:0] op);
    return op inside {OP_LDW, OP_LDB, OP_STW};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline bus between stages: the master drives the payload, the slave
// returns busy back-pressure.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic [OPCODE_WIDTH-1:0] opcode;
  logic [REG_WIDTH-1:0]    alu_out;
  logic [REG_WIDTH-1:0]    store_data;
  logic [REG_WIDTH-1:0]    mem_out;
  logic [IDX_WIDTH-1:0]    dest_reg_idx;
  logic                    fetch_stall;
  logic                    dep_stall;
  logic                    mem_busy;

  modport master (
    output opcode, alu_out, store_data, mem_out, dest_reg_idx,
           fetch_stall, dep_stall,
    input  mem_busy
  );

  modport slave (
    input  opcode, alu_out, store_data, mem_out, dest_reg_idx,
           fetch_stall, dep_stall,
    output mem_busy
  );

endinterface

// File: rtl/mem_stage_dmem_ram.sv
// Single-port word-addressed data RAM: synchronous write, no reset.
module dmem_ram #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read is combinational so the completion edge can register load data directly.
  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: owns data memory, runs LDW/LDB/STW with a fixed
// latency and back-pressures execute while an access is in flight.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DMEM_AW     = 10,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        I_CLOCK,
  input  logic        I_LOCK,
  mem_stage_if.slave  ex,
  mem_stage_if.master wb
);

  state_t                  state, state_n;
  logic [3:0]              cnt, cnt_n;
  logic [OPCODE_WIDTH-1:0] hold_op, acc_op;
  logic [REG_WIDTH-1:0]    hold_alu, hold_sd, acc_alu, acc_sd;
  logic [IDX_WIDTH-1:0]    hold_idx, acc_idx;
  logic                    in_valid, capture, done, sel_hold, ram_we;
  logic [DMEM_AW-1:0]      ram_addr;
  logic [REG_WIDTH-1:0]    rdata;
  wb_t                     out_q, out_n;

  assign in_valid = !ex.fetch_stall && !ex.dep_stall;
  assign acc_op   = sel_hold ? hold_op  : ex.opcode;
  assign acc_alu  = sel_hold ? hold_alu : ex.alu_out;
  assign acc_sd   = sel_hold ? hold_sd  : ex.store_data;
  assign acc_idx  = sel_hold ? hold_idx : ex.dest_reg_idx;
  assign ram_addr = acc_alu[DMEM_AW-1:0];
  // Reset on the completion edge aborts the store.
  assign ram_we   = done && (acc_op == OP_STW) && I_LOCK;

  dmem_ram #(.AW(DMEM_AW), .DW(REG_WIDTH)) u_ram (
    .clk   (I_CLOCK),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (acc_sd),
    .rdata (rdata)
  );

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    capture  = 1'b0;
    done     = 1'b0;
    sel_hold = 1'b0;
    out_n    = WB_BUBBLE;
    case (state)
      IDLE: begin
        if (in_valid && is_mem_op(ex.opcode)) begin
          if (MEM_LATENCY == 1) begin
            done = 1'b1;
          end else begin
            capture = 1'b1;
            cnt_n   = 4'(MEM_LATENCY - 1);
            state_n = ACCESS;
          end
        end else begin
          out_n.opcode       = ex.opcode;
          out_n.alu_out      = ex.alu_out;
          out_n.mem_out      = '0;
          out_n.dest_reg_idx = ex.dest_reg_idx;
          out_n.fetch_stall  = ex.fetch_stall;
          out_n.dep_stall    = ex.dep_stall;
        end
      end
      ACCESS: begin
        sel_hold = 1'b1;
        if (cnt == 4'd1) begin
          done    = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (done) begin
      out_n.opcode       = acc_op;
      out_n.alu_out      = acc_alu;
      out_n.dest_reg_idx = acc_idx;
      out_n.fetch_stall  = 1'b0;
      out_n.dep_stall    = 1'b0;
      case (acc_op)
        OP_LDW:  out_n.mem_out = rdata;
        OP_LDB:  out_n.mem_out = {{(REG_WIDTH-8){1'b0}}, rdata[7:0]};
        default: out_n.mem_out = '0;
      endcase
    end
  end

  always_ff @(posedge I_CLOCK) begin
    if (!I_LOCK) begin
      state <= IDLE;
      cnt   <= '0;
      out_q <= WB_BUBBLE;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      out_q <= out_n;
    end
  end

  always_ff @(posedge I_CLOCK) begin
    if (capture) begin
      hold_op  <= ex.opcode;
      hold_alu <= ex.alu_out;
      hold_sd  <= ex.store_data;
      hold_idx <= ex.dest_reg_idx;
    end
  end

  assign ex.mem_busy     = (state == ACCESS);
  assign wb.opcode       = out_q.opcode;
  assign wb.alu_out      = out_q.alu_out;
  assign wb.mem_out      = out_q.mem_out;
  assign wb.dest_reg_idx = out_q.dest_reg_idx;
  assign wb.fetch_stall  = out_q.fetch_stall;
  assign wb.dep_stall    = out_q.dep_stall;
  assign wb.store_data   = '0;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: three instances with MEM_LATENCY 1, 2 and 4
// receive identical stimulus; each is checked against its own latency.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk  = 1'b0;
  logic lock = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if ex1 (), ex2 (), ex4 ();
  mem_stage_if wb1 (), wb2 (), wb4 ();

  mem_stage #(.DMEM_AW(10), .MEM_LATENCY(1)) dut1 (
    .I_CLOCK(clk), .I_LOCK(lock), .ex(ex1), .wb(wb1));
  mem_stage #(.DMEM_AW(10), .MEM_LATENCY(2)) dut2 (
    .I_CLOCK(clk), .I_LOCK(lock), .ex(ex2), .wb(wb2));
  mem_stage #(.DMEM_AW(10), .MEM_LATENCY(4)) dut4 (
    .I_CLOCK(clk), .I_LOCK(lock), .ex(ex4), .wb(wb4));

  int checks = 0;
  int errors = 0;
  int unsigned lat_cfg [3] = '{1, 2, 4};

  task automatic drive(input logic [7:0] op, input logic [15:0] alu,
                       input logic [15:0] sd, input logic [3:0] idx,
                       input logic fs, input logic ds);
    ex1.opcode = op; ex1.alu_out = alu; ex1.store_data = sd;
    ex1.dest_reg_idx = idx; ex1.fetch_stall = fs; ex1.dep_stall = ds;
    ex2.opcode = op; ex2.alu_out = alu; ex2.store_data = sd;
    ex2.dest_reg_idx = idx; ex2.fetch_stall = fs; ex2.dep_stall = ds;
    ex4.opcode = op; ex4.alu_out = alu; ex4.store_data = sd;
    ex4.dest_reg_idx = idx; ex4.fetch_stall = fs; ex4.dep_stall = ds;
  endtask

  task automatic sample(input int d, output wb_t o, output logic busy);
    case (d)
      0: begin
        o.opcode = wb1.opcode; o.alu_out = wb1.alu_out; o.mem_out = wb1.mem_out;
        o.dest_reg_idx = wb1.dest_reg_idx; o.fetch_stall = wb1.fetch_stall;
        o.dep_stall = wb1.dep_stall; busy = ex1.mem_busy;
      end
      1: begin
        o.opcode = wb2.opcode; o.alu_out = wb2.alu_out; o.mem_out = wb2.mem_out;
        o.dest_reg_idx = wb2.dest_reg_idx; o.fetch_stall = wb2.fetch_stall;
        o.dep_stall = wb2.dep_stall; busy = ex2.mem_busy;
      end
      default: begin
        o.opcode = wb4.opcode; o.alu_out = wb4.alu_out; o.mem_out = wb4.mem_out;
        o.dest_reg_idx = wb4.dest_reg_idx; o.fetch_stall = wb4.fetch_stall;
        o.dep_stall = wb4.dep_stall; busy = ex4.mem_busy;
      end
    endcase
  endtask

  task automatic chk(input string tag, input string field, input int d,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s.%s L=%0d got=%h exp=%h", tag, field, lat_cfg[d], got, exp);
    end
  endtask

  // Present one op for one edge, then bubbles; every instance must deliver
  // the result exactly at its latency edge, bubbles elsewhere.
  task automatic run_op(input string tag, input logic [7:0] op,
                        input logic [15:0] alu, input logic [15:0] sd,
                        input logic [3:0] idx, input logic fs, input logic ds,
                        input logic [15:0] m1, input logic [15:0] m2,
                        input logic [15:0] m4);
    wb_t         o;
    logic        b;
    int unsigned lat;
    logic [15:0] em;
    drive(op, alu, sd, idx, fs, ds);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) drive(8'h00, 16'h0000, 16'h0000, 4'h0, 1'b1, 1'b0);
      for (int d = 0; d < 3; d++) begin
        lat = (!fs && !ds && is_mem_op(op)) ? lat_cfg[d] : 1;
        em  = (d == 0) ? m1 : (d == 1) ? m2 : m4;
        sample(d, o, b);
        chk(tag, "busy", d, 32'(b), 32'(k < lat));
        if (k == lat) begin
          chk(tag, "opcode",  d, 32'(o.opcode),       32'(op));
          chk(tag, "alu_out", d, 32'(o.alu_out),      32'(alu));
          chk(tag, "mem_out", d, 32'(o.mem_out),      32'(em));
          chk(tag, "idx",     d, 32'(o.dest_reg_idx), 32'(idx));
          chk(tag, "fstall",  d, 32'(o.fetch_stall),  32'(fs));
          chk(tag, "dstall",  d, 32'(o.dep_stall),    32'(ds));
        end else begin
          chk(tag, "bubble", d, 32'(o.fetch_stall), 32'd1);
        end
      end
    end
  endtask

  task automatic chk_reset_state(input string tag);
    wb_t  o;
    logic b;
    for (int d = 0; d < 3; d++) begin
      sample(d, o, b);
      chk(tag, "fstall", d, 32'(o.fetch_stall), 32'd1);
      chk(tag, "opcode", d, 32'(o.opcode),      32'd0);
      chk(tag, "busy",   d, 32'(b),             32'd0);
    end
  endtask

  initial begin
    ex1.mem_out = '0; ex2.mem_out = '0; ex4.mem_out = '0;
    wb1.mem_busy = 1'b0; wb2.mem_busy = 1'b0; wb4.mem_busy = 1'b0;

    // reset with a valid ADD presented
    lock = 1'b0;
    drive(OP_ADD, 16'h1234, 16'h0000, 4'h3, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    lock = 1'b1;
    drive(8'h00, 16'h0000, 16'h0000, 4'h0, 1'b1, 1'b0);
    @(posedge clk); #1;

    run_op("add", OP_ADD, 16'h1234, 16'h0000, 4'h3, 1'b0, 1'b0,
           16'h0000, 16'h0000, 16'h0000);
    run_op("unk", 8'hFF, 16'h0005, 16'h0000, 4'h1, 1'b0, 1'b0,
           16'h0000, 16'h0000, 16'h0000);

    run_op("stw5", OP_STW, 16'h0005, 16'hBEEF, 4'h2, 1'b0, 1'b0,
           16'h0000, 16'h0000, 16'h0000);
    run_op("ldw5", OP_LDW, 16'h0005, 16'h0000, 4'h4, 1'b0, 1'b0,
           16'hBEEF, 16'hBEEF, 16'hBEEF);
    run_op("ldb5", OP_LDB, 16'h0005, 16'h0000, 4'h5, 1'b0, 1'b0,
           16'h00EF, 16'h00EF, 16'h00EF);

    run_op("stwwrap", OP_STW, 16'h0405, 16'hAAAA, 4'h6, 1'b0, 1'b0,
           16'h0000, 16'h0000, 16'h0000);
    run_op("ldwwrap", OP_LDW, 16'h0005, 16'h0000, 4'h7, 1'b0, 1'b0,
           16'hAAAA, 16'hAAAA, 16'hAAAA);

    run_op("pre7", OP_STW, 16'h0007, 16'h0000, 4'h0, 1'b0, 1'b0,
           16'h0000, 16'h0000, 16'h0000);
    run_op("bubstw", OP_STW, 16'h0007, 16'hFFFF, 4'h8, 1'b0, 1'b1,
           16'h0000, 16'h0000, 16'h0000);
    run_op("ldw7", OP_LDW, 16'h0007, 16'h0000, 4'h9, 1'b0, 1'b0,
           16'h0000, 16'h0000, 16'h0000);

    // reset on the edge after accepting a store
    run_op("pre9", OP_STW, 16'h0009, 16'h0000, 4'h0, 1'b0, 1'b0,
           16'h0000, 16'h0000, 16'h0000);
    drive(OP_STW, 16'h0009, 16'h1111, 4'hA, 1'b0, 1'b0);
    @(posedge clk); #1;
    lock = 1'b0;
    drive(8'h00, 16'h0000, 16'h0000, 4'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk_reset_state("midrst");
    lock = 1'b1;
    @(posedge clk); #1;
    // latency 1 finished its store on the accept edge, before reset
    run_op("ldw9", OP_LDW, 16'h0009, 16'h0000, 4'hB, 1'b0, 1'b0,
           16'h1111, 16'h0000, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
